// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator between the MEM stage and the
// doubleword-addressed data memory. Handles one request at a time.
// Sub-doubleword stores are done as read-modify-write; loads are lane-extracted
// and zero/sign-extended. A one-cycle response pulse ends every request.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, misaligned
// requests skip memory and respond with resp_err=1. When it is undefined,
// misaligned offsets are aligned down and resp_err stays 0.
module lsu_mem_master #(
  parameter int WORD     = 64,
  parameter int ADDR_LSB = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  output logic [WORD-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t                st;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [WORD-1:0]       addr_q;
  logic [WORD-1:0]       wdata_q;
  logic [WORD-1:0]       rd_buf;
  logic [ADDR_LSB-1:0]   off_q;

  // Byte offset forced down to the natural alignment of the access size.
  function automatic logic [ADDR_LSB-1:0] align_off(input logic [ADDR_LSB-1:0] off,
                                                    input logic [1:0] size);
    case (size)
      2'b00:   align_off = off;
      2'b01:   align_off = {off[2:1], 1'b0};
      2'b10:   align_off = {off[2], 2'b00};
      default: align_off = 3'b000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [ADDR_LSB-1:0] off,
                                      input logic [1:0] size);
    misaligned = (align_off(off, size) != off);
  endfunction

  function automatic logic [WORD-1:0] field_mask(input logic [1:0] size);
    case (size)
      2'b00:   field_mask = 64'h0000_0000_0000_00FF;
      2'b01:   field_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   field_mask = 64'h0000_0000_FFFF_FFFF;
      default: field_mask = '1;
    endcase
  endfunction

  // Pull the field at off down to bit 0 and extend it to a full doubleword.
  function automatic logic [WORD-1:0] extract(input logic [WORD-1:0] dw,
                                              input logic [ADDR_LSB-1:0] off,
                                              input logic [1:0] size,
                                              input logic sgn);
    logic [WORD-1:0] sh;
    sh = dw >> {off, 3'b000};
    case (size)
      2'b00:   extract = {{56{sgn & sh[7]}},  sh[7:0]};
      2'b01:   extract = {{48{sgn & sh[15]}}, sh[15:0]};
      2'b10:   extract = {{32{sgn & sh[31]}}, sh[31:0]};
      default: extract = sh;
    endcase
  endfunction

  // Replace the field at off inside the previously read doubleword.
  function automatic logic [WORD-1:0] merge(input logic [WORD-1:0] base,
                                            input logic [WORD-1:0] wd,
                                            input logic [ADDR_LSB-1:0] off,
                                            input logic [1:0] size);
    logic [WORD-1:0] fm;
    fm    = field_mask(size);
    merge = (base & ~(fm << {off, 3'b000})) | ((wd & fm) << {off, 3'b000});
  endfunction

  assign req_ready = (st == S_IDLE) && rst_n;
  assign off_q     = align_off(addr_q[ADDR_LSB-1:0], size_q);

  // Write data is only driven while the write strobe is up.
  assign mem_wdata = !mem_write ? '0 :
                     (size_q == 2'b11) ? wdata_q : merge(rd_buf, wdata_q, off_q, size_q);

  // Load data and error are only visible during the response pulse.
  assign resp_rdata = (resp_valid && !we_q && !resp_err) ?
                      extract(rd_buf, off_q, size_q, signed_q) : '0;

  // Request FSM: captures the request and sequences read, write and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_buf     <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (st)
        S_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (TRAP_EN && misaligned(req_addr[ADDR_LSB-1:0], req_size)) begin
              st         <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_we || req_size != 2'b11) begin
              st       <= S_RD;
              mem_read <= 1'b1;
              mem_addr <= {req_addr[WORD-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
            end else begin
              st        <= S_WR;
              mem_write <= 1'b1;
              mem_addr  <= {req_addr[WORD-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
            end
          end
        end
        S_RD: begin
          rd_buf <= mem_rdata;
          if (we_q) begin
            st        <= S_WR;
            mem_write <= 1'b1;
            mem_addr  <= {addr_q[WORD-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
          end else begin
            st         <= S_RESP;
            resp_valid <= 1'b1;
          end
        end
        S_WR: begin
          st         <= S_RESP;
          resp_valid <= 1'b1;
        end
        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

endmodule
